// File: rtl/cache_access_ctrl.sv
// Request sequencer for a 2-way set-associative cache: owns tag/valid/LRU state,
// performs hit/miss lookup, sequences 4-word line refills and write-through stores.
module cache_access_ctrl #(
    parameter int TAGW = 6,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            CpuReq,
    input  logic            CpuWe,
    input  logic [TAGW+5:0] CpuAddr,
    input  logic [DW-1:0]   CpuWdata,
    output logic            CpuReady,
    output logic            CpuDone,
    output logic [DW-1:0]   CpuRdata,
    output logic [3:0]      SetIndex,
    output logic            SetEnable,
    output logic            DataWay,
    output logic [1:0]      DataWord,
    output logic            DataWe,
    output logic [DW-1:0]   DataWdata,
    input  logic [DW-1:0]   DataRdata,
    output logic            MemRdReq,
    output logic            MemWrReq,
    output logic [TAGW+5:0] MemAddr,
    output logic [DW-1:0]   MemWdata,
    input  logic            MemRdValid,
    input  logic [DW-1:0]   MemRdata,
    input  logic            MemWrAck
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REFILL = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [TAGW+5:0] r_addr;
    logic            r_we;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic [TAGW-1:0] r_tag [0:1][0:15];
    logic [15:0]     r_valid [0:1];
    logic [15:0]     r_lru;
    logic            r_victim;
    logic [1:0]      r_cnt;

    logic [TAGW-1:0] w_tag;
    logic [3:0]      w_idx;
    logic [1:0]      w_off;
    logic            w_hit0;
    logic            w_hit1;
    logic            w_hit;
    logic            w_hit_way;
    logic            w_victim;
    logic            w_last_word;

    assign w_tag       = r_addr[TAGW+5:6];
    assign w_idx       = r_addr[5:2];
    assign w_off       = r_addr[1:0];
    assign w_hit0      = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1      = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit       = w_hit0 || w_hit1;
    assign w_hit_way   = w_hit1;
    // Fill an empty way before evicting; otherwise the LRU bit names the victim.
    assign w_victim    = !r_valid[0][w_idx] ? 1'b0 :
                         !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_last_word = MemRdValid && (r_cnt == 2'd3);

    assign CpuReady = (r_state == ST_IDLE);
    assign CpuDone  = (r_state == ST_DONE);
    assign CpuRdata = r_rdata;
    assign SetIndex = w_idx;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (CpuReq) begin
                    w_state_next = ST_LOOKUP;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (r_we) begin
                    w_state_next = ST_WRITE;
                end else if (w_hit) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (w_last_word) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_REFILL;
                end
            end
            ST_WRITE: begin
                if (MemWrAck) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request capture, tag/valid/LRU bookkeeping, refill counter and load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= {(TAGW+6){1'b0}};
            r_we     <= 1'b0;
            r_wdata  <= {DW{1'b0}};
            r_rdata  <= {DW{1'b0}};
            r_lru    <= 16'h0000;
            r_victim <= 1'b0;
            r_cnt    <= 2'd0;
            r_valid[0] <= 16'h0000;
            r_valid[1] <= 16'h0000;
            for (int s = 0; s < 16; s++) begin
                r_tag[0][s] <= {TAGW{1'b0}};
                r_tag[1][s] <= {TAGW{1'b0}};
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (CpuReq) begin
                        r_addr  <= CpuAddr;
                        r_we    <= CpuWe;
                        r_wdata <= CpuWdata;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_lru[w_idx] <= ~w_hit_way;
                        if (!r_we) begin
                            r_rdata <= DataRdata;
                        end
                    end else if (!r_we) begin
                        // Invalidate now so an interrupted refill never leaves a stale line.
                        r_victim <= w_victim;
                        r_cnt    <= 2'd0;
                        r_valid[w_victim][w_idx] <= 1'b0;
                    end
                end
                ST_REFILL: begin
                    if (MemRdValid) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == w_off) begin
                            r_rdata <= MemRdata;
                        end
                        if (r_cnt == 2'd3) begin
                            r_tag[r_victim][w_idx]   <= w_tag;
                            r_valid[r_victim][w_idx] <= 1'b1;
                            r_lru[w_idx]             <= ~r_victim;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Data-array and memory-side strobes; every write strobe is paired with SetEnable.
    always_comb begin
        SetEnable = 1'b0;
        DataWay   = 1'b0;
        DataWord  = 2'd0;
        DataWe    = 1'b0;
        DataWdata = {DW{1'b0}};
        MemRdReq  = 1'b0;
        MemWrReq  = 1'b0;
        MemAddr   = {(TAGW+6){1'b0}};
        MemWdata  = {DW{1'b0}};
        case (r_state)
            ST_LOOKUP: begin
                SetEnable = 1'b1;
                DataWord  = w_off;
                if (w_hit) begin
                    DataWay = w_hit_way;
                end else begin
                    DataWay = 1'b0;
                end
                if (r_we && w_hit) begin
                    DataWe    = 1'b1;
                    DataWdata = r_wdata;
                end else if (!r_we && !w_hit) begin
                    MemRdReq = 1'b1;
                    MemAddr  = {w_tag, w_idx, 2'b00};
                end else begin
                    DataWe = 1'b0;
                end
            end
            ST_REFILL: begin
                DataWay  = r_victim;
                DataWord = r_cnt;
                if (MemRdValid) begin
                    SetEnable = 1'b1;
                    DataWe    = 1'b1;
                    DataWdata = MemRdata;
                end else begin
                    SetEnable = 1'b0;
                end
            end
            ST_WRITE: begin
                MemWrReq = 1'b1;
                MemAddr  = r_addr;
                MemWdata = r_wdata;
            end
            default: begin
                SetEnable = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Directed bench for cache_access_ctrl with a behavioural 2x16x4 data array.
module tb_cache_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        CpuReq = 1'b0;
    logic        CpuWe = 1'b0;
    logic [11:0] CpuAddr = 12'h000;
    logic [15:0] CpuWdata = 16'h0000;
    logic        CpuReady, CpuDone;
    logic [15:0] CpuRdata;
    logic [3:0]  SetIndex;
    logic        SetEnable, DataWay, DataWe;
    logic [1:0]  DataWord;
    logic [15:0] DataWdata, DataRdata;
    logic        MemRdReq, MemWrReq;
    logic [11:0] MemAddr;
    logic [15:0] MemWdata;
    logic        MemRdValid = 1'b0;
    logic [15:0] MemRdata = 16'h0000;
    logic        MemWrAck = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int rdreq_cnt = 0;
    int datawe_cnt = 0;
    logic [15:0] mem [0:1][0:15][0:3];

    cache_access_ctrl #(.TAGW(6), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWdata(CpuWdata),
        .CpuReady(CpuReady), .CpuDone(CpuDone), .CpuRdata(CpuRdata),
        .SetIndex(SetIndex), .SetEnable(SetEnable), .DataWay(DataWay),
        .DataWord(DataWord), .DataWe(DataWe), .DataWdata(DataWdata), .DataRdata(DataRdata),
        .MemRdReq(MemRdReq), .MemWrReq(MemWrReq), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdValid(MemRdValid), .MemRdata(MemRdata), .MemWrAck(MemWrAck)
    );

    always #5 clk = ~clk;

    assign DataRdata = SetEnable ? mem[DataWay][SetIndex][DataWord] : 16'h0000;

    always @(posedge clk) begin
        if (SetEnable && DataWe) mem[DataWay][SetIndex][DataWord] <= DataWdata;
        if (MemRdReq) rdreq_cnt <= rdreq_cnt + 1;
        if (DataWe) datawe_cnt <= datawe_cnt + 1;
    end

    task automatic issue(input logic we, input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        CpuReq = 1'b1; CpuWe = we; CpuAddr = a; CpuWdata = d;
        @(negedge clk);
        CpuReq = 1'b0;
        #1;
    endtask

    task automatic refill(input logic [15:0] base, input int nwords);
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            MemRdValid = 1'b1; MemRdata = base + 16'(i);
        end
        @(negedge clk);
        MemRdValid = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (CpuReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: actual %0h required 1", CpuReady); end
        n_checks++; if (CpuDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: actual %0h required 0", CpuDone); end
        n_checks++; if (CpuRdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: actual %0h required 0", CpuRdata); end
        n_checks++; if ({SetIndex, SetEnable, DataWe, MemRdReq, MemWrReq} !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: actual %0h required 0", {SetIndex, SetEnable, DataWe, MemRdReq, MemWrReq}); end
        n_checks++; if ({MemAddr, MemWdata, DataWdata, DataWay, DataWord} !== 47'h0) begin n_fail++; $display("FAIL reset_bus: actual %0h required 0", {MemAddr, MemWdata, DataWdata, DataWay, DataWord}); end
    endtask

    task automatic test_cold_miss;
        int rd0;
        rd0 = rdreq_cnt;
        issue(1'b0, 12'h104, 16'h0000);
        n_checks++; if (MemRdReq !== 1'b1) begin n_fail++; $display("FAIL cold_rdreq: actual %0h required 1", MemRdReq); end
        n_checks++; if (MemAddr !== 12'h104) begin n_fail++; $display("FAIL cold_memaddr: actual %0h required 104", MemAddr); end
        n_checks++; if (CpuReady !== 1'b0) begin n_fail++; $display("FAIL cold_ready: actual %0h required 0", CpuReady); end
        refill(16'h00A0, 4);
        n_checks++; if (CpuDone !== 1'b1) begin n_fail++; $display("FAIL cold_done: actual %0h required 1", CpuDone); end
        n_checks++; if (CpuRdata !== 16'h00A0) begin n_fail++; $display("FAIL cold_rdata: actual %0h required a0", CpuRdata); end
        n_checks++; if (rdreq_cnt - rd0 !== 1) begin n_fail++; $display("FAIL cold_rdreq_count: actual %0d required 1", rdreq_cnt - rd0); end
        n_checks++; if ({mem[0][1][0], mem[0][1][3]} !== 32'h00A0_00A3) begin n_fail++; $display("FAIL cold_fill_way0: actual %0h required a000a3", {mem[0][1][0], mem[0][1][3]}); end
        @(negedge clk); #1;
        n_checks++; if ({CpuDone, CpuReady} !== 2'b01) begin n_fail++; $display("FAIL cold_back_idle: actual %0h required 1", {CpuDone, CpuReady}); end
    endtask

    task automatic test_load_hit;
        int rd0;
        rd0 = rdreq_cnt;
        issue(1'b0, 12'h107, 16'h0000);
        n_checks++; if ({SetEnable, SetIndex, DataWay, DataWord} !== 8'b1_0001_0_11) begin n_fail++; $display("FAIL hit_lookup: actual %0h required %0h", {SetEnable, SetIndex, DataWay, DataWord}, 8'b1_0001_0_11); end
        n_checks++; if ({MemRdReq, CpuDone} !== 2'b00) begin n_fail++; $display("FAIL hit_no_req: actual %0h required 0", {MemRdReq, CpuDone}); end
        @(negedge clk); #1;
        n_checks++; if (CpuDone !== 1'b1) begin n_fail++; $display("FAIL hit_done: actual %0h required 1", CpuDone); end
        n_checks++; if (CpuRdata !== 16'h00A3) begin n_fail++; $display("FAIL hit_rdata: actual %0h required a3", CpuRdata); end
        n_checks++; if (SetEnable !== 1'b0) begin n_fail++; $display("FAIL hit_setenable_done: actual %0h required 0", SetEnable); end
        n_checks++; if (rdreq_cnt !== rd0) begin n_fail++; $display("FAIL hit_rdreq_count: actual %0d required %0d", rdreq_cnt, rd0); end
    endtask

    task automatic test_store_hit;
        int we0;
        we0 = datawe_cnt;
        issue(1'b1, 12'h105, 16'h55AA);
        n_checks++; if ({DataWe, DataWay, DataWord} !== 4'b1_0_01) begin n_fail++; $display("FAIL sthit_we: actual %0h required 9", {DataWe, DataWay, DataWord}); end
        n_checks++; if (DataWdata !== 16'h55AA) begin n_fail++; $display("FAIL sthit_wdata: actual %0h required 55aa", DataWdata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++; if ({MemWrReq, MemAddr, MemWdata} !== {1'b1, 12'h105, 16'h55AA}) begin n_fail++; $display("FAIL sthit_wrreq_%0d: actual %0h required %0h", i, {MemWrReq, MemAddr, MemWdata}, {1'b1, 12'h105, 16'h55AA}); end
            if (i == 2) MemWrAck = 1'b1;
        end
        @(negedge clk);
        MemWrAck = 1'b0;
        #1;
        n_checks++; if ({CpuDone, MemWrReq} !== 2'b10) begin n_fail++; $display("FAIL sthit_done: actual %0h required 2", {CpuDone, MemWrReq}); end
        n_checks++; if (CpuRdata !== 16'h00A3) begin n_fail++; $display("FAIL sthit_rdata_held: actual %0h required a3", CpuRdata); end
        n_checks++; if (datawe_cnt - we0 !== 1) begin n_fail++; $display("FAIL sthit_we_count: actual %0d required 1", datawe_cnt - we0); end
        issue(1'b0, 12'h105, 16'h0000);
        @(negedge clk); #1;
        n_checks++; if ({CpuDone, CpuRdata} !== {1'b1, 16'h55AA}) begin n_fail++; $display("FAIL sthit_readback: actual %0h required %0h", {CpuDone, CpuRdata}, {1'b1, 16'h55AA}); end
    endtask

    task automatic test_lru_evict;
        int rd0;
        issue(1'b0, 12'h204, 16'h0000);
        n_checks++; if ({MemRdReq, MemAddr} !== {1'b1, 12'h204}) begin n_fail++; $display("FAIL lru_miss1: actual %0h required 1204", {MemRdReq, MemAddr}); end
        refill(16'h00B0, 4);
        n_checks++; if ({CpuDone, CpuRdata} !== {1'b1, 16'h00B0}) begin n_fail++; $display("FAIL lru_miss1_data: actual %0h required 100b0", {CpuDone, CpuRdata}); end
        n_checks++; if (mem[1][1][0] !== 16'h00B0) begin n_fail++; $display("FAIL lru_fill_way1: actual %0h required b0", mem[1][1][0]); end
        issue(1'b0, 12'h304, 16'h0000);
        n_checks++; if ({MemRdReq, MemAddr} !== {1'b1, 12'h304}) begin n_fail++; $display("FAIL lru_miss2: actual %0h required 1304", {MemRdReq, MemAddr}); end
        refill(16'h00C0, 4);
        n_checks++; if ({mem[0][1][0], mem[1][1][0]} !== 32'h00C0_00B0) begin n_fail++; $display("FAIL lru_evict_way0: actual %0h required c000b0", {mem[0][1][0], mem[1][1][0]}); end
        rd0 = rdreq_cnt;
        issue(1'b0, 12'h206, 16'h0000);
        n_checks++; if ({MemRdReq, DataWay} !== 2'b01) begin n_fail++; $display("FAIL lru_keep_hit: actual %0h required 1", {MemRdReq, DataWay}); end
        @(negedge clk); #1;
        n_checks++; if ({CpuDone, CpuRdata} !== {1'b1, 16'h00B2}) begin n_fail++; $display("FAIL lru_keep_data: actual %0h required 100b2", {CpuDone, CpuRdata}); end
        n_checks++; if (rdreq_cnt !== rd0) begin n_fail++; $display("FAIL lru_keep_count: actual %0d required %0d", rdreq_cnt, rd0); end
    endtask

    task automatic test_store_miss;
        int we0;
        we0 = datawe_cnt;
        issue(1'b1, 12'h3F0, 16'h1234);
        n_checks++; if ({DataWe, MemRdReq} !== 2'b00) begin n_fail++; $display("FAIL stmiss_lookup: actual %0h required 0", {DataWe, MemRdReq}); end
        @(negedge clk);
        MemWrAck = 1'b1;
        CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 12'h104;
        #1;
        n_checks++; if ({MemWrReq, MemAddr, MemWdata} !== {1'b1, 12'h3F0, 16'h1234}) begin n_fail++; $display("FAIL stmiss_wrreq: actual %0h required %0h", {MemWrReq, MemAddr, MemWdata}, {1'b1, 12'h3F0, 16'h1234}); end
        @(negedge clk);
        MemWrAck = 1'b0; CpuReq = 1'b0;
        #1;
        n_checks++; if (CpuDone !== 1'b1) begin n_fail++; $display("FAIL stmiss_done: actual %0h required 1", CpuDone); end
        @(negedge clk); #1;
        n_checks++; if ({CpuReady, MemRdReq, SetEnable} !== 3'b100) begin n_fail++; $display("FAIL stmiss_req_ignored: actual %0h required 4", {CpuReady, MemRdReq, SetEnable}); end
        n_checks++; if (datawe_cnt !== we0) begin n_fail++; $display("FAIL stmiss_no_datawe: actual %0d required %0d", datawe_cnt, we0); end
        issue(1'b0, 12'h3F0, 16'h0000);
        n_checks++; if ({MemRdReq, MemAddr} !== {1'b1, 12'h3F0}) begin n_fail++; $display("FAIL stmiss_load_miss: actual %0h required 13f0", {MemRdReq, MemAddr}); end
        refill(16'h00D0, 4);
        n_checks++; if ({CpuDone, CpuRdata} !== {1'b1, 16'h00D0}) begin n_fail++; $display("FAIL stmiss_load_data: actual %0h required 100d0", {CpuDone, CpuRdata}); end
    endtask

    task automatic test_reset_mid_refill;
        issue(1'b0, 12'h104, 16'h0000);
        n_checks++; if ({MemRdReq, MemAddr} !== {1'b1, 12'h104}) begin n_fail++; $display("FAIL rstmid_miss: actual %0h required 1104", {MemRdReq, MemAddr}); end
        refill(16'h00E0, 2);
        reset = 1'b1;
        #1;
        n_checks++; if ({CpuReady, CpuDone, SetEnable, DataWe, MemRdReq, MemWrReq} !== 6'b100000) begin n_fail++; $display("FAIL rstmid_ctrl: actual %0h required 20", {CpuReady, CpuDone, SetEnable, DataWe, MemRdReq, MemWrReq}); end
        n_checks++; if ({CpuRdata, SetIndex, MemAddr} !== 32'h0) begin n_fail++; $display("FAIL rstmid_bus: actual %0h required 0", {CpuRdata, SetIndex, MemAddr}); end
        @(negedge clk);
        reset = 1'b0;
        MemRdValid = 1'b1; MemRdata = 16'h00EE;
        @(negedge clk);
        MemRdValid = 1'b0;
        #1;
        n_checks++; if ({CpuDone, CpuReady, DataWe} !== 3'b010) begin n_fail++; $display("FAIL rstmid_stray_valid: actual %0h required 2", {CpuDone, CpuReady, DataWe}); end
        issue(1'b0, 12'h104, 16'h0000);
        n_checks++; if ({MemRdReq, MemAddr} !== {1'b1, 12'h104}) begin n_fail++; $display("FAIL rstmid_refetch: actual %0h required 1104", {MemRdReq, MemAddr}); end
        refill(16'h00F0, 4);
        n_checks++; if ({CpuDone, CpuRdata} !== {1'b1, 16'h00F0}) begin n_fail++; $display("FAIL rstmid_refetch_data: actual %0h required 100f0", {CpuDone, CpuRdata}); end
    endtask

    initial begin
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++)
                for (int k = 0; k < 4; k++)
                    mem[w][s][k] = 16'h0000;
        test_reset();
        test_cold_miss();
        test_load_hit();
        test_store_hit();
        test_lru_evict();
        test_store_miss();
        test_reset_mid_refill();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
